// File: rtl/data_mem_arbiter.sv
// Two-port (CPU / DMA-debug) arbiter in front of a single-ported byte-addressed data memory.
// Each transaction runs IDLE -> ACCESS -> RESP; misaligned or out-of-range requests skip ACCESS.
module data_mem_arbiter #(
  parameter int MEM_BYTES = 128,
  parameter bit A_PRIO    = 1'b0
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        a_req,
  input  logic        a_rw,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_ack,
  output logic        a_err,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_rw,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_ack,
  output logic        b_err,
  output logic [31:0] b_rdata,
  output logic        m_RW,
  output logic [31:0] m_DAddr,
  output logic [31:0] m_DataIn,
  input  logic [31:0] m_result
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

  logic [1:0]  state;
  logic        win_b;
  logic        last_b;
  logic        lat_rw;
  logic        lat_err;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic        any_req;
  logic        pick_b;
  logic        sel_rw;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_fault;

  function automatic logic addr_fault(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr > MAX_ADDR);
  endfunction

  // Winner selection: fixed A priority, or the port not granted last on a tie.
  always_comb begin
    any_req = a_req | b_req;
    pick_b  = 1'b0;
    if (A_PRIO) begin
      pick_b = b_req & ~a_req;
    end else if (a_req && b_req) begin
      pick_b = ~last_b;
    end else begin
      pick_b = b_req;
    end
    sel_rw    = pick_b ? b_rw    : a_rw;
    sel_addr  = pick_b ? b_addr  : a_addr;
    sel_wdata = pick_b ? b_wdata : a_wdata;
    sel_fault = addr_fault(sel_addr);
  end

  // Control state and load-data capture.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      win_b   <= 1'b0;
      last_b  <= 1'b1;
      lat_rw  <= 1'b0;
      lat_err <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            win_b   <= pick_b;
            last_b  <= pick_b;
            lat_rw  <= sel_rw;
            lat_err <= sel_fault;
            state   <= sel_fault ? RESP : ACCESS;
          end
        end
        ACCESS: begin
          if (!lat_rw) begin
            if (win_b) begin
              b_rdata <= m_result;
            end else begin
              a_rdata <= m_result;
            end
          end
          state <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Address/data of the granted request; only observed while in ACCESS.
  always_ff @(posedge CLK) begin
    if (state == IDLE && any_req) begin
      lat_addr  <= sel_addr;
      lat_wdata <= sel_wdata;
    end
  end

  // Memory side is driven only during ACCESS, so reset or a fault never writes.
  always_comb begin
    m_RW     = (state == ACCESS) & lat_rw;
    m_DAddr  = (state == ACCESS) ? lat_addr  : '0;
    m_DataIn = (state == ACCESS) ? lat_wdata : '0;
  end

  always_comb begin
    a_ack = (state == RESP) & ~win_b;
    b_ack = (state == RESP) &  win_b;
    a_err = a_ack & lat_err;
    b_err = b_ack & lat_err;
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: vector table plus multi-cycle arbitration/reset sequences.
module tb_data_mem_arbiter;

  localparam int MEMB = 128;

  logic        CLK;
  logic        Reset;
  logic        a_req, a_rw, b_req, b_rw;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_ack, a_err, b_ack, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        m_RW;
  logic [31:0] m_DAddr, m_DataIn, m_result;

  logic        a2_req, a2_rw, b2_req, b2_rw;
  logic [31:0] a2_addr, a2_wdata, b2_addr, b2_wdata;
  logic        a2_ack, a2_err, b2_ack, b2_err;
  logic [31:0] a2_rdata, b2_rdata;
  logic        m2_RW;
  logic [31:0] m2_DAddr, m2_DataIn, m2_result;

  logic [7:0] mem [0:MEMB-1];

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int wr2_cnt = 0;
  int both_cnt = 0;
  int exp_wr = 0;

  data_mem_arbiter #(.MEM_BYTES(MEMB), .A_PRIO(1'b0)) dut (
    .CLK(CLK), .Reset(Reset),
    .a_req(a_req), .a_rw(a_rw), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_rw(b_rw), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .m_RW(m_RW), .m_DAddr(m_DAddr), .m_DataIn(m_DataIn), .m_result(m_result)
  );

  data_mem_arbiter #(.MEM_BYTES(MEMB), .A_PRIO(1'b1)) dut_prio (
    .CLK(CLK), .Reset(Reset),
    .a_req(a2_req), .a_rw(a2_rw), .a_addr(a2_addr), .a_wdata(a2_wdata),
    .a_ack(a2_ack), .a_err(a2_err), .a_rdata(a2_rdata),
    .b_req(b2_req), .b_rw(b2_rw), .b_addr(b2_addr), .b_wdata(b2_wdata),
    .b_ack(b2_ack), .b_err(b2_err), .b_rdata(b2_rdata),
    .m_RW(m2_RW), .m_DAddr(m2_DAddr), .m_DataIn(m2_DataIn), .m_result(m2_result)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    return (a < 32'(MEMB)) ? mem[a[6:0]] : 8'h00;
  endfunction

  // Big-endian memory model: combinational read, falling-edge write.
  always_comb begin
    m_result = {rd_byte(m_DAddr), rd_byte(m_DAddr + 32'd1),
                rd_byte(m_DAddr + 32'd2), rd_byte(m_DAddr + 32'd3)};
  end

  always @(negedge CLK) begin
    if (m_RW) begin
      for (int i = 0; i < 4; i++) begin
        logic [31:0] wa;
        wa = m_DAddr + 32'(i);
        if (wa < 32'(MEMB)) mem[wa[6:0]] <= m_DataIn[31-8*i -: 8];
      end
    end
  end

  assign m2_result = 32'h7700_0000 | m2_DAddr;

  always @(negedge CLK) begin
    if (m_RW) wr_cnt = wr_cnt + 1;
    if (m2_RW) wr2_cnt = wr2_cnt + 1;
    if (a_ack && b_ack) both_cnt = both_cnt + 1;
  end

  typedef struct {
    logic        port_b;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic trans(input int idx);
    vec_t v;
    int n;
    int wr0;
    logic got;
    string nm;
    v = vecs[idx];
    nm = $sformatf("vec%0d", idx);
    wr0 = wr_cnt;
    @(negedge CLK);
    if (v.port_b) begin
      b_req = 1'b1; b_rw = v.rw; b_addr = v.addr; b_wdata = v.wdata;
    end else begin
      a_req = 1'b1; a_rw = v.rw; a_addr = v.addr; a_wdata = v.wdata;
    end
    got = 1'b0;
    n = 0;
    while (!got && n < 10) begin
      @(posedge CLK); #1;
      n++;
      if (n == 1 && !v.err) begin
        chk({nm, "_daddr"}, m_DAddr, v.addr);
        chk({nm, "_mrw"}, 32'(m_RW), 32'(v.rw));
      end
      got = v.port_b ? b_ack : a_ack;
    end
    if (!got) begin
      chk({nm, "_ack_timeout"}, 32'(got), 32'd1);
    end else begin
      chk({nm, "_latency"}, 32'(n), v.err ? 32'd1 : 32'd2);
      chk({nm, "_err"}, 32'(v.port_b ? b_err : a_err), 32'(v.err));
      chk({nm, "_rdata"}, v.port_b ? b_rdata : a_rdata, v.rdata);
    end
    if (v.rw && !v.err) exp_wr++;
    chk({nm, "_writes"}, 32'(wr_cnt - wr0), (v.rw && !v.err) ? 32'd1 : 32'd0);
    a_req = 1'b0;
    b_req = 1'b0;
    @(posedge CLK); #1;
  endtask

  initial begin
    int ack_cyc [$];
    logic ack_b [$];
    int exp_cyc [4];
    logic exp_b [4];
    int na, first_b, errs, aborted;

    for (int i = 0; i < MEMB; i++) mem[i] = 8'h00;
    Reset = 1'b1;
    a_req = 0; a_rw = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_rw = 0; b_addr = 0; b_wdata = 0;
    a2_req = 0; a2_rw = 0; a2_addr = 0; a2_wdata = 0;
    b2_req = 0; b2_rw = 0; b2_addr = 0; b2_wdata = 0;

    vecs[0]  = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b1, 32'h02, 32'h55555555, 1'b1, 32'h0};
    vecs[3]  = '{1'b1, 1'b1, 32'h80, 32'h66666666, 1'b1, 32'h0};
    vecs[4]  = '{1'b1, 1'b1, 32'h7C, 32'h01020304, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 32'h7C, 32'h0,        1'b0, 32'h01020304};
    vecs[6]  = '{1'b0, 1'b0, 32'h7D, 32'h0,        1'b1, 32'hDEADBEEF};
    vecs[7]  = '{1'b0, 1'b0, 32'h84, 32'h0,        1'b1, 32'hDEADBEEF};
    vecs[8]  = '{1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[9]  = '{1'b0, 1'b1, 32'h00, 32'hCAFEF00D, 1'b0, 32'hDEADBEEF};
    vecs[10] = '{1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 32'hCAFEF00D};
    vecs[11] = '{1'b1, 1'b0, 32'h7E, 32'h0,        1'b1, 32'hDEADBEEF};

    @(posedge CLK); #1;
    chk("reset_ctrl", {27'd0, a_ack, b_ack, a_err, b_err, m_RW}, 32'd0);
    chk("reset_a_rdata", a_rdata, 32'd0);
    chk("reset_b_rdata", b_rdata, 32'd0);
    chk("reset_daddr", m_DAddr, 32'd0);
    chk("reset_datain", m_DataIn, 32'd0);
    @(negedge CLK);
    Reset = 1'b0;

    for (int i = 0; i < 12; i++) trans(i);

    chk("mem_10", {mem[16], mem[17], mem[18], mem[19]}, 32'hDEADBEEF);
    chk("mem_7c", {mem[124], mem[125], mem[126], mem[127]}, 32'h01020304);
    chk("mem_00", {mem[0], mem[1], mem[2], mem[3]}, 32'hCAFEF00D);
    chk("mem_04_untouched", {16'd0, mem[4], mem[5]}, 32'd0);

    // Simultaneous loads out of reset, held continuously: A, B, A, B every 3 cycles.
    @(negedge CLK); Reset = 1'b1;
    @(negedge CLK); Reset = 1'b0;
    a_req = 1; a_rw = 0; a_addr = 32'h10;
    b_req = 1; b_rw = 0; b_addr = 32'h7C;
    for (int k = 1; k <= 11; k++) begin
      @(posedge CLK); #1;
      if (a_ack) begin ack_cyc.push_back(k); ack_b.push_back(1'b0); end
      if (b_ack) begin ack_cyc.push_back(k); ack_b.push_back(1'b1); end
    end
    a_req = 0; b_req = 0;
    exp_cyc = '{2, 5, 8, 11};
    exp_b   = '{1'b0, 1'b1, 1'b0, 1'b1};
    chk("rr_ack_count", 32'(ack_cyc.size()), 32'd4);
    for (int i = 0; i < 4 && i < ack_cyc.size(); i++) begin
      chk($sformatf("rr_cycle%0d", i), 32'(ack_cyc[i]), 32'(exp_cyc[i]));
      chk($sformatf("rr_port%0d", i), 32'(ack_b[i]), 32'(exp_b[i]));
    end
    chk("rr_a_rdata", a_rdata, 32'hDEADBEEF);
    chk("rr_b_rdata", b_rdata, 32'h01020304);
    @(posedge CLK); #1;

    // Reset inside the ACCESS cycle of a store, before the falling edge.
    @(negedge CLK);
    a_req = 1; a_rw = 1; a_addr = 32'h20; a_wdata = 32'h11223344;
    @(posedge CLK); #1;
    chk("abort_access_mrw", 32'(m_RW), 32'd1);
    chk("abort_access_addr", m_DAddr, 32'h20);
    #1 Reset = 1'b1;
    #1;
    chk("abort_ctrl", {27'd0, a_ack, b_ack, a_err, b_err, m_RW}, 32'd0);
    chk("abort_outs", m_DAddr | m_DataIn | a_rdata | b_rdata, 32'd0);
    a_req = 0;
    #4 Reset = 1'b0;
    aborted = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      if (a_ack) aborted++;
    end
    chk("abort_no_ack", 32'(aborted), 32'd0);
    chk("abort_mem_20", {mem[32], mem[33], mem[34], mem[35]}, 32'd0);
    vecs[0] = '{1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0};
    a_rdata_seed: begin end
    trans(0);

    // Fixed priority instance: B starves until A drops its request.
    @(negedge CLK);
    a2_req = 1; a2_rw = 0; a2_addr = 32'h40; a2_wdata = 32'h13572468;
    b2_req = 1; b2_rw = 0; b2_addr = 32'h44; b2_wdata = 32'h0;
    na = 0; first_b = 0; errs = 0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge CLK); #1;
      if (k == 1) begin
        chk("prio_daddr", m2_DAddr, 32'h40);
        chk("prio_datain", m2_DataIn, 32'h13572468);
      end
      if (a2_ack) na++;
      if (a2_err || b2_err) errs++;
      if (b2_ack && first_b == 0) begin
        first_b = k;
        b2_req = 0;
      end
      if (k == 11) a2_req = 0;
    end
    a2_req = 0; b2_req = 0;
    chk("prio_a_acks", 32'(na), 32'd4);
    chk("prio_b_first_ack", 32'(first_b), 32'd14);
    chk("prio_errs", 32'(errs), 32'd0);
    chk("prio_a_rdata", a2_rdata, 32'h77000040);
    chk("prio_b_rdata", b2_rdata, 32'h77000044);
    chk("prio_no_writes", 32'(wr2_cnt), 32'd0);

    chk("store_write_pulses", 32'(wr_cnt), 32'(exp_wr));
    chk("dual_ack_cycles", 32'(both_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
